// File: rtl/x_nibble_tx_if.sv
// Upstream sample handshake into the nibble transmitter.
// Transfer on a clock edge where in_valid and in_ready are both high; data is held stable while in_valid & !in_ready.
interface x_nibble_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/x_nibble_tx.sv
// Nibble-serial sample transmitter feeding the HPF x_half input: FIFO-buffered, one sample per filter frame.
// Optional SYNC_ON_Z_EN: resynchronise the slot counter to the filter's z_valid strobe.
module x_nibble_tx #(
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  x_nibble_tx_if.slave                  in_if,
  output logic [3:0]                    x_half,
  output logic                          sent,
  output logic                          underrun,
  output logic [$clog2(DEPTH):0]        level,
  input  logic                          z_valid,
  output logic                          sync_err,
  output logic [$clog2(FRAME_LEN)-1:0]  dbg_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_LEN);

  // Slot counter positions, named after the filter state occupying that slot.
  localparam logic [CW-1:0] SLOT_OUT_Z  = CW'(0);
  localparam logic [CW-1:0] SLOT_WAIT_X = CW'(1);
  localparam logic [CW-1:0] SLOT_GET_X0 = CW'(2);
  localparam logic [CW-1:0] SLOT_LAST   = CW'(FRAME_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [3:0]    x_half_q, x_half_d;
  logic [3:0]    hold_q, hold_d;
  logic          sent_q, sent_d;
  logic          underrun_q, underrun_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    head;
  logic          push, pop, resync;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    resync = 1'b0;
`ifdef SYNC_ON_Z_EN
    resync = z_valid && (cnt_q != SLOT_OUT_Z);
`endif
    // in_ready depends only on the registered level, never on this cycle's pop.
    push = in_if.in_valid && (level_q != LW'(DEPTH));
    pop  = (cnt_q == SLOT_WAIT_X) && (level_q != '0) && !resync;

    cnt_d      = (cnt_q == SLOT_LAST) ? '0 : cnt_q + 1'b1;
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    level_d    = level_q + LW'(push) - LW'(pop);
    x_half_d   = '0;
    hold_d     = hold_q;
    sent_d     = 1'b0;
    underrun_d = 1'b0;

    if (cnt_q == SLOT_WAIT_X) begin
      x_half_d   = pop ? head[3:0] : 4'h0;
      hold_d     = pop ? head[7:4] : 4'h0;
      underrun_d = !pop;
    end else if (cnt_q == SLOT_GET_X0) begin
      x_half_d = hold_q;
      sent_d   = 1'b1;
    end

    // A resync restarts the frame at WAIT_X and drops whatever nibble was in flight.
    if (resync) begin
      cnt_d      = SLOT_WAIT_X;
      x_half_d   = '0;
      hold_d     = '0;
      sent_d     = 1'b0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      x_half_q   <= '0;
      hold_q     <= '0;
      sent_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      x_half_q   <= x_half_d;
      hold_q     <= hold_d;
      sent_q     <= sent_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset: the pointers and level decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.in_data;
  end

`ifdef SYNC_ON_Z_EN
  logic sync_err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_err_q <= 1'b0;
    else        sync_err_q <= resync;
  end
  assign sync_err = sync_err_q;
`else
  logic unused_z_valid;
  assign unused_z_valid = z_valid | resync;
  assign sync_err       = 1'b0;
`endif

  assign in_if.in_ready = (level_q != LW'(DEPTH));
  assign x_half         = x_half_q;
  assign sent           = sent_q;
  assign underrun       = underrun_q;
  assign level          = level_q;
  assign dbg_cnt        = cnt_q;

endmodule

// File: tb/tb_x_nibble_tx.sv
// Directed bench for x_nibble_tx: frame timing, FIFO ordering/backpressure, underrun, reset and z_valid handling.
module tb_x_nibble_tx;
  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 20;

  logic       clk;
  logic       reset;
  logic [3:0] x_half;
  logic       sent;
  logic       underrun;
  logic [2:0] level;
  logic       z_valid;
  logic       sync_err;
  logic [4:0] dbg_cnt;

  x_nibble_tx_if u_if ();

  x_nibble_tx #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_if    (u_if),
    .x_half   (x_half),
    .sent     (sent),
    .underrun (underrun),
    .level    (level),
    .z_valid  (z_valid),
    .sync_err (sync_err),
    .dbg_cnt  (dbg_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks; sampling and driving both happen 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    exp_cnt = (exp_cnt == FRAME_LEN - 1) ? 0 : exp_cnt + 1;
  endtask

  task automatic wait_cnt(input int target);
    for (int i = 0; i < FRAME_LEN && exp_cnt != target; i++) step();
  endtask

  task automatic push_byte(input logic [7:0] d);
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    step();
    u_if.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;
    z_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    checks++; if (x_half !== 4'h0) begin errors++; $display("FAIL reset_x_half: got %h expected 0", x_half); end
    checks++; if (sent !== 1'b0) begin errors++; $display("FAIL reset_sent: got %b expected 0", sent); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", u_if.in_ready); end
    checks++; if (dbg_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", dbg_cnt); end
  endtask

  // T1: single sample pushed before WAIT_X goes out in the same frame.
  task automatic test_single();
    push_byte(8'hA5);
    checks++; if (dbg_cnt !== 5'd1) begin errors++; $display("FAIL t1_cnt1: got %0d expected 1", dbg_cnt); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL t1_level: got %0d expected 1", level); end
    checks++; if (x_half !== 4'h0) begin errors++; $display("FAIL t1_idle: got %h expected 0", x_half); end
    step();
    checks++; if (x_half !== 4'h5) begin errors++; $display("FAIL t1_lo: got %h expected 5", x_half); end
    checks++; if (sent !== 1'b0) begin errors++; $display("FAIL t1_sent_lo: got %b expected 0", sent); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL t1_underrun: got %b expected 0", underrun); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL t1_level_pop: got %0d expected 0", level); end
    step();
    checks++; if (x_half !== 4'hA) begin errors++; $display("FAIL t1_hi: got %h expected a", x_half); end
    checks++; if (sent !== 1'b1) begin errors++; $display("FAIL t1_sent_hi: got %b expected 1", sent); end
    step();
    checks++; if (x_half !== 4'h0) begin errors++; $display("FAIL t1_after: got %h expected 0", x_half); end
    checks++; if (sent !== 1'b0) begin errors++; $display("FAIL t1_sent_after: got %b expected 0", sent); end
  endtask

  // T2: four samples back to back fill the FIFO and drain one per frame in order.
  task automatic test_back_to_back();
    logic [7:0] v [4];
    v[0] = 8'h01; v[1] = 8'h80; v[2] = 8'h7F; v[3] = 8'hFF;
    wait_cnt(4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_%0d: got %b expected 1", i, u_if.in_ready); end
      push_byte(v[i]);
      exp_q.push_back(v[i]);
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL t2_full_level: got %0d expected 4", level); end
    checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL t2_full_ready: got %b expected 0", u_if.in_ready); end
    for (int k = 0; k < 4; k++) begin
      wait_cnt(2);
      exp_b = exp_q.pop_front();
      checks++; if (x_half !== exp_b[3:0]) begin errors++; $display("FAIL t2_lo_%0d: got %h expected %h", k, x_half, exp_b[3:0]); end
      checks++; if (level !== 3'(3 - k)) begin errors++; $display("FAIL t2_level_%0d: got %0d expected %0d", k, level, 3 - k); end
      step();
      checks++; if (x_half !== exp_b[7:4]) begin errors++; $display("FAIL t2_hi_%0d: got %h expected %h", k, x_half, exp_b[7:4]); end
      checks++; if (sent !== 1'b1) begin errors++; $display("FAIL t2_sent_%0d: got %b expected 1", k, sent); end
    end
  endtask

  // T4: push attempted with a full FIFO across the pop edge is taken one cycle later.
  task automatic test_full_pop();
    logic [7:0] v [4];
    v[0] = 8'h12; v[1] = 8'h34; v[2] = 8'h56; v[3] = 8'h78;
    wait_cnt(4);
    for (int i = 0; i < 4; i++) begin
      push_byte(v[i]);
      exp_q.push_back(v[i]);
    end
    wait_cnt(1);
    checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL t4_ready_full: got %b expected 0", u_if.in_ready); end
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'h9A;
    step();
    exp_b = exp_q.pop_front();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL t4_level_pop: got %0d expected 3", level); end
    checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL t4_ready_after_pop: got %b expected 1", u_if.in_ready); end
    checks++; if (x_half !== exp_b[3:0]) begin errors++; $display("FAIL t4_lo: got %h expected %h", x_half, exp_b[3:0]); end
    step();
    u_if.in_valid = 1'b0;
    exp_q.push_back(8'h9A);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL t4_level_refill: got %0d expected 4", level); end
    checks++; if (x_half !== exp_b[7:4]) begin errors++; $display("FAIL t4_hi: got %h expected %h", x_half, exp_b[7:4]); end
    for (int k = 0; k < 4; k++) begin
      wait_cnt(2);
      exp_b = exp_q.pop_front();
      checks++; if (x_half !== exp_b[3:0]) begin errors++; $display("FAIL t4_drain_lo_%0d: got %h expected %h", k, x_half, exp_b[3:0]); end
      step();
      checks++; if (x_half !== exp_b[7:4]) begin errors++; $display("FAIL t4_drain_hi_%0d: got %h expected %h", k, x_half, exp_b[7:4]); end
    end
  endtask

  // T3: two idle frames send zeros and flag one underrun per frame.
  task automatic test_underrun();
    int pulses = 0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      step();
      if (underrun === 1'b1) pulses++;
      checks++; if (x_half !== 4'h0) begin errors++; $display("FAIL t3_x_half_c%0d: got %h expected 0", exp_cnt, x_half); end
      checks++; if (underrun !== (exp_cnt == 2)) begin errors++; $display("FAIL t3_underrun_c%0d: got %b expected %b", exp_cnt, underrun, exp_cnt == 2); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL t3_level: got %0d expected 0", level); end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL t3_pulses: got %0d expected 2", pulses); end
  endtask

`ifdef SYNC_ON_Z_EN
  // T6: mid-frame z_valid restarts the frame at WAIT_X.
  task automatic test_resync();
    wait_cnt(4);
    push_byte(8'hC3);
    wait_cnt(7);
    z_valid = 1'b1;
    step();
    z_valid = 1'b0;
    exp_cnt = 1;
    checks++; if (dbg_cnt !== 5'd1) begin errors++; $display("FAIL t6_cnt: got %0d expected 1", dbg_cnt); end
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL t6_sync_err: got %b expected 1", sync_err); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL t6_level: got %0d expected 1", level); end
    step();
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL t6_sync_err_clr: got %b expected 0", sync_err); end
    checks++; if (x_half !== 4'h3) begin errors++; $display("FAIL t6_lo: got %h expected 3", x_half); end
    step();
    checks++; if (x_half !== 4'hC) begin errors++; $display("FAIL t6_hi: got %h expected c", x_half); end
    checks++; if (sent !== 1'b1) begin errors++; $display("FAIL t6_sent: got %b expected 1", sent); end
  endtask
`else
  // Without the resync option z_valid has no effect on the counter.
  task automatic test_z_ignored();
    wait_cnt(7);
    z_valid = 1'b1;
    step();
    z_valid = 1'b0;
    checks++; if (dbg_cnt !== 5'd8) begin errors++; $display("FAIL z_ignored_cnt: got %0d expected 8", dbg_cnt); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL z_ignored_sync_err: got %b expected 0", sync_err); end
  endtask
`endif

  // T5: reset in GET_X0 with samples queued clears everything at once.
  task automatic test_reset_mid_frame();
    wait_cnt(4);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_cnt(2);
    checks++; if (x_half !== 4'h1) begin errors++; $display("FAIL t5_pre_lo: got %h expected 1", x_half); end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL t5_pre_level: got %0d expected 3", level); end
    reset = 1'b0;
    #1;
    checks++; if (x_half !== 4'h0) begin errors++; $display("FAIL t5_x_half: got %h expected 0", x_half); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL t5_level: got %0d expected 0", level); end
    checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL t5_in_ready: got %b expected 1", u_if.in_ready); end
    checks++; if (dbg_cnt !== 5'd0) begin errors++; $display("FAIL t5_cnt: got %0d expected 0", dbg_cnt); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_cnt = 0;
    push_byte(8'h96);
    step();
    checks++; if (x_half !== 4'h6) begin errors++; $display("FAIL t5_post_lo: got %h expected 6", x_half); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL t5_post_underrun: got %b expected 0", underrun); end
    step();
    checks++; if (x_half !== 4'h9) begin errors++; $display("FAIL t5_post_hi: got %h expected 9", x_half); end
    checks++; if (sent !== 1'b1) begin errors++; $display("FAIL t5_post_sent: got %b expected 1", sent); end
    wait_cnt(2);
    checks++; if (x_half !== 4'h0) begin errors++; $display("FAIL t5_discard_lo: got %h expected 0", x_half); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL t5_discard_underrun: got %b expected 1", underrun); end
  endtask

  initial begin
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;
    z_valid = 1'b0;
    do_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_underrun();
`ifdef SYNC_ON_Z_EN
    test_resync();
`else
    test_z_ignored();
`endif
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
